// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receive path.
package uart_pkg;
  typedef enum logic [2:0] {
    INICIAL, INICIO, DADOS, PARIDADE, PARADA, ESPERA
  } estado_t;

  localparam int DATA_BITS        = 8;
  localparam int PARITY_ODD       = 1;
  localparam int CLKS_PER_BIT_DEF = 434;
endpackage

// File: rtl/uart_rx_sincronizador.sv
// Two-flop synchroniser for an asynchronous single-bit input.
module sincronizador #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clock,
  input  logic reset,
  input  logic d,
  output logic q
);
  logic s1;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      s1 <= RST_VAL;
      q  <= RST_VAL;
    end else begin
      s1 <= d;
      q  <= s1;
    end
  end
endmodule

// File: rtl/uart_rx.sv
// UART receiver: 8 data bits LSB first, odd parity, 1 stop, centre sampling.
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 entrada_serial,
  output logic [DATA_BITS-1:0] dados_ascii,
  output logic                 pronto,
  output logic                 erro_paridade,
  output logic                 erro_parada,
  output logic                 recebendo
);
  localparam int          CW       = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] CNT_FULL = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] CNT_HALF = CW'(CLKS_PER_BIT / 2 - 1);

  logic                 rx_s;
  estado_t              estado;
  logic [CW-1:0]        cnt;
  logic [3:0]           idx;
  logic [DATA_BITS-1:0] sr;
  logic                 par_err;

  sincronizador #(.RST_VAL(1'b1)) u_sinc (
    .clock (clock),
    .reset (reset),
    .d     (entrada_serial),
    .q     (rx_s)
  );

  assign recebendo = (estado != INICIAL);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      estado        <= INICIAL;
      cnt           <= '0;
      idx           <= '0;
      sr            <= '0;
      par_err       <= 1'b0;
      dados_ascii   <= '0;
      pronto        <= 1'b0;
      erro_paridade <= 1'b0;
      erro_parada   <= 1'b0;
    end else begin
      pronto <= 1'b0;
      case (estado)
        INICIAL: if (!rx_s) begin
          estado <= INICIO;
          cnt    <= '0;
        end
        INICIO: if (cnt == CNT_HALF) begin
          cnt <= '0;
          // a start bit that is high again at its centre was only a glitch
          if (!rx_s) begin
            estado <= DADOS;
            idx    <= '0;
          end else begin
            estado <= INICIAL;
          end
        end else begin
          cnt <= cnt + 1'b1;
        end
        DADOS: if (cnt == CNT_FULL) begin
          cnt <= '0;
          sr  <= {rx_s, sr[DATA_BITS-1:1]};
          idx <= idx + 1'b1;
          if (idx == 4'(DATA_BITS - 1)) estado <= PARIDADE;
        end else begin
          cnt <= cnt + 1'b1;
        end
        PARIDADE: if (cnt == CNT_FULL) begin
          cnt     <= '0;
          par_err <= (^{sr, rx_s}) != 1'(PARITY_ODD);
          estado  <= PARADA;
        end else begin
          cnt <= cnt + 1'b1;
        end
        PARADA: if (cnt == CNT_FULL) begin
          cnt           <= '0;
          dados_ascii   <= sr;
          erro_paridade <= par_err;
          erro_parada   <= ~rx_s;
          pronto        <= 1'b1;
          estado        <= rx_s ? INICIAL : ESPERA;
        end else begin
          cnt <= cnt + 1'b1;
        end
        // line held low past the stop bit: wait for idle before re-arming
        ESPERA: if (rx_s) estado <= INICIAL;
        default: estado <= INICIAL;
      endcase
    end
  end
endmodule
